// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// A frame word is {stop, payload[7:0] LSB-first, start}.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    SHIFT = 2'd3
  } uart_tx_state_t;

  localparam int FRAME_BITS           = 10;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  localparam logic [FRAME_BITS-1:0] LINE_IDLE_WORD = 10'h3FF;

  // A word is sendable only with a low start bit and a high stop bit.
  function automatic logic frame_ok(input logic [FRAME_BITS-1:0] word);
    return (word[0] == 1'b0) && (word[FRAME_BITS-1] == 1'b1);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-boundary tick generator: o_tick is high on the last clock of each bit period.
// i_clear holds the counter at zero so a new frame starts on a full bit period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_count;

  assign o_tick = (r_count == LAST_COUNT);

  // Free-running bit-period counter, wrapping at the last clock of the bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear || o_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter that pulls pre-framed 10-bit words from a FIFO and shifts them out.
// The line is driven straight from bit 0 of the shift register, so it only moves on bit boundaries.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fifo_empty,
  output logic                  fifo_read,
  input  logic [FRAME_BITS-1:0] fifo_data,
  input  logic                  tx_enable,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_error
);

  uart_tx_state_t        r_state;
  logic [FRAME_BITS-1:0] r_shift;
  logic [3:0]            r_bit_cnt;
  logic                  r_armed;

  logic w_tick;
  logic w_baud_clear;
  logic w_start_ok;
  logic w_last_bit;

  assign w_baud_clear = (r_state != SHIFT);
  assign w_start_ok   = tx_enable && !fifo_empty && r_armed;
  assign w_last_bit   = (r_bit_cnt == 4'(FRAME_BITS - 1));
  assign tx           = r_shift[0];

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clock  (clock),
    .reset  (reset),
    .i_clear(w_baud_clear),
    .o_tick (w_tick)
  );

  // Frame sequencer; r_armed delays the first fetch by one clock after reset release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_shift     <= LINE_IDLE_WORD;
      r_bit_cnt   <= 4'd0;
      r_armed     <= 1'b0;
      fifo_read   <= 1'b0;
      busy        <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      r_armed     <= 1'b1;
      fifo_read   <= 1'b0;
      frame_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_state   <= FETCH;
            fifo_read <= 1'b1;
            busy      <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        FETCH: begin
          r_state <= LOAD;
        end
        LOAD: begin
          r_bit_cnt <= 4'd0;
          if (frame_ok(fifo_data)) begin
            r_shift <= fifo_data;
            r_state <= SHIFT;
          end else begin
            r_shift     <= LINE_IDLE_WORD;
            frame_error <= 1'b1;
            busy        <= 1'b0;
            r_state     <= IDLE;
          end
        end
        SHIFT: begin
          if (w_tick) begin
            // Shifting in ones leaves the register at the idle pattern after the stop bit.
            r_shift <= {1'b1, r_shift[FRAME_BITS-1:1]};
            if (w_last_bit) begin
              r_bit_cnt <= 4'd0;
              // Chaining straight into FETCH keeps the inter-frame gap at two idle clocks.
              if (w_start_ok) begin
                r_state   <= FETCH;
                fifo_read <= 1'b1;
              end else begin
                r_state <= IDLE;
                busy    <= 1'b0;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end else begin
            r_state <= SHIFT;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_shift   <= LINE_IDLE_WORD;
          r_bit_cnt <= 4'd0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench: a FIFO model feeds words, a scoreboard of expected frames is checked bit by bit on tx.
module tb_uart_tx_serializer;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = CPB * 10;

  logic       clock       = 1'b0;
  logic       reset       = 1'b1;
  logic       fifo_empty  = 1'b1;
  logic       tx_enable   = 1'b0;
  logic [9:0] fifo_data   = 10'h3FF;
  logic       fifo_read;
  logic       tx;
  logic       busy;
  logic       frame_error;

  int chk_cnt     = 0;
  int pass_cnt    = 0;
  int fail_cnt    = 0;
  int cyc_num     = 0;
  int frames_done = 0;
  int starts      = 0;
  int rd_cnt      = 0;
  int rd_viol     = 0;
  int fe_cnt      = 0;
  int mon_cyc     = 0;
  bit in_frame    = 1'b0;

  logic [9:0] fifo_q[$];
  logic [9:0] exp_q[$];
  int         start_times[$];

  uart_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
    .clock      (clock),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_read  (fifo_read),
    .fifo_data  (fifo_data),
    .tx_enable  (tx_enable),
    .tx         (tx),
    .busy       (busy),
    .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] mk(input logic [7:0] payload);
    return {1'b1, payload, 1'b0};
  endfunction

  task automatic push_word(input logic [9:0] w);
    fifo_q.push_back(w);
    if (w[0] == 1'b0 && w[9] == 1'b1) exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_frames(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(tag, 32'(frames_done >= target), 32'd1);
  endtask

  task automatic wait_mon_cyc(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (!(in_frame && mon_cyc == target) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(tag, 32'(in_frame && mon_cyc == target), 32'd1);
  endtask

  initial forever begin
    @(posedge clock);
    cyc_num++;
  end

  // FIFO model: word valid the cycle after fifo_read, otherwise the data bus carries junk.
  initial begin
    int hold;
    hold = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        hold = 0;
      end else if (fifo_read === 1'b1) begin
        rd_cnt++;
        if (fifo_q.size() == 0) rd_viol++;
        else fifo_data = fifo_q.pop_front();
        hold = 1;
      end else if (hold > 0) begin
        hold = 0;
      end else begin
        fifo_data = 10'($urandom);
      end
      if (!reset && frame_error === 1'b1) fe_cnt++;
      fifo_empty = (fifo_q.size() == 0);
    end
  end

  // Line monitor: a falling edge on an idle line starts a frame, compared against the scoreboard.
  initial begin
    logic [9:0] cur;
    logic       prev_tx;
    cur     = 10'h3FF;
    prev_tx = 1'b1;
    forever begin
      @(negedge clock);
      if (reset) begin
        in_frame = 1'b0;
        prev_tx  = 1'b1;
      end else begin
        if (!in_frame && prev_tx === 1'b1 && tx === 1'b0) begin
          check("sb_has_frame", 32'(exp_q.size() > 0), 32'd1);
          cur = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
          start_times.push_back(cyc_num);
          starts++;
          in_frame = 1'b1;
          mon_cyc  = 0;
        end
        if (in_frame) begin
          check("tx_bit", 32'(tx), 32'(cur[mon_cyc / CPB]));
          check("busy_in_frame", 32'(busy), 32'd1);
          mon_cyc++;
          if (mon_cyc == FRAME_CYC) begin
            in_frame = 1'b0;
            frames_done++;
          end
        end
        prev_tx = tx;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_rd, base_fr, base_fe, base_st, bad;

    reset     = 1'b1;
    tx_enable = 1'b0;
    idle(3);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fifo_read", 32'(fifo_read), 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);

    // Single 0x55 frame; first fetch must wait for the second edge after release.
    push_word(mk(8'h55));
    tx_enable = 1'b1;
    reset     = 1'b0;
    @(negedge clock);
    check("no_fetch_edge1", 32'(fifo_read), 32'd0);
    @(negedge clock);
    check("fetch_edge2", 32'(fifo_read), 32'd1);
    wait_frames("t1_frame", 1, 80);
    idle(1);
    check("t1_tx_idle", 32'(tx), 32'd1);
    check("t1_busy_done", 32'(busy), 32'd0);
    check("t1_reads", 32'(rd_cnt), 32'd1);

    // Back-to-back frames separated by exactly two idle clocks.
    base_rd = rd_cnt;
    base_fr = frames_done;
    push_word(mk(8'h00));
    push_word(mk(8'hFF));
    wait_frames("t2_frames", base_fr + 2, 200);
    idle(2);
    check("t2_start_spacing", 32'(start_times[$] - start_times[$-1]), 32'(FRAME_CYC + 2));
    check("t2_reads", 32'(rd_cnt - base_rd), 32'd2);

    // Bad start bit, bad stop bit, then a good word.
    base_rd = rd_cnt;
    base_fr = frames_done;
    base_fe = fe_cnt;
    base_st = starts;
    push_word(10'h3FF);
    push_word(10'h024);
    push_word(mk(8'hA5));
    wait_frames("t3_frame", base_fr + 1, 200);
    idle(2);
    check("t3_frame_errors", 32'(fe_cnt - base_fe), 32'd2);
    check("t3_reads", 32'(rd_cnt - base_rd), 32'd3);
    check("t3_starts", 32'(starts - base_st), 32'd1);

    // Empty FIFO with transmit enabled.
    base_rd = rd_cnt;
    bad = 0;
    repeat (100) begin
      @(negedge clock);
      if (fifo_read !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("t4_idle_bad_cycles", 32'(bad), 32'd0);
    check("t4_reads", 32'(rd_cnt - base_rd), 32'd0);

    // Reset in the middle of bit 5 (a zero bit of 0xC3).
    base_st = starts;
    base_fr = frames_done;
    push_word(mk(8'hC3));
    wait_mon_cyc("t5_reach_bit5", 22, 100);
    #1 reset = 1'b1;
    #1;
    check("t5_tx_async", 32'(tx), 32'd1);
    check("t5_busy_async", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    bad = 0;
    repeat (60) begin
      @(negedge clock);
      if (tx !== 1'b1) bad++;
    end
    check("t5_line_high_after", 32'(bad), 32'd0);
    check("t5_starts", 32'(starts - base_st), 32'd1);
    check("t5_no_frame_done", 32'(frames_done - base_fr), 32'd0);

    // Drop tx_enable during bit 3 with a second word waiting.
    base_rd = rd_cnt;
    base_fr = frames_done;
    push_word(mk(8'h3C));
    push_word(mk(8'h81));
    wait_mon_cyc("t6_reach_bit3", 13, 100);
    tx_enable = 1'b0;
    wait_frames("t6_first_done", base_fr + 1, 100);
    idle(30);
    check("t6_reads_held", 32'(rd_cnt - base_rd), 32'd1);
    check("t6_frames_held", 32'(frames_done - base_fr), 32'd1);
    check("t6_busy_held", 32'(busy), 32'd0);
    check("t6_word_waiting", 32'(fifo_q.size()), 32'd1);
    tx_enable = 1'b1;
    wait_frames("t6_second_done", base_fr + 2, 100);
    check("t6_reads_final", 32'(rd_cnt - base_rd), 32'd2);

    idle(4);
    check("no_read_when_empty", 32'(rd_viol), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
